// File: rtl/dp_mem_if.sv
// Datapath <-> memory responder bus: fetch, data access, loader port and status.
interface dp_mem_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        ihit;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic [31:0] dmemload;
  logic        dhit;
  logic        halt;
  logic        prog_wen;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        busy;
  logic        addr_err;

  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
           halt, prog_wen, prog_addr, prog_data,
    input  imemload, ihit, dmemload, dhit, busy, addr_err
  );

  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
           halt, prog_wen, prog_addr, prog_data,
    output imemload, ihit, dmemload, dhit, busy, addr_err
  );
endinterface

// File: rtl/dp_mem_responder.sv
// Single-port word RAM answering fetch and data requests with fixed latency;
// data requests win arbitration, results are registered and pulse for one cycle.
module dp_mem_responder #(
  parameter int          DEPTH    = 256,
  parameter int          LAT      = 2,
  parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
  input logic     CLK,
  input logic     RST,
  dp_mem_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HIT} state_t;
  typedef enum logic [1:0] {ACC_I, ACC_DR, ACC_DW} acc_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  acc_t            typ_q, typ_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     store_q, store_d;
  logic            err_q, err_d;
  logic            ihit_q, ihit_d;
  logic            dhit_q, dhit_d;
  logic            aerr_q, aerr_d;
  logic [31:0]     imemload_q, dmemload_q;

  logic [31:0]     mem [0:DEPTH-1];
  logic            ram_we;
  logic [AW-1:0]   ram_idx;
  logic [31:0]     ram_wdata;
  logic            ld_i, ld_d, ld_err;

  logic            acc_go, acc_err;
  acc_t            acc_typ;
  logic [AW-1:0]   acc_idx;
  logic            fire;
  acc_t            f_typ;
  logic [AW-1:0]   f_idx;
  logic [31:0]     f_store;
  logic            f_err;
  logic            prog_in_range;
  logic            unused_prog_lsb;

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH));
  endfunction

  // Loader ignores byte offset; words beyond the RAM are silently discarded.
  assign prog_in_range   = ({2'b00, bus.prog_addr[31:2]} < 32'(DEPTH));
  assign unused_prog_lsb = ^bus.prog_addr[1:0];

  // Candidate access presented on the bus this cycle (only taken in IDLE).
  always_comb begin
    acc_go  = 1'b0;
    acc_typ = ACC_I;
    acc_idx = bus.imemaddr[AW+1:2];
    acc_err = 1'b0;
    if (!bus.prog_wen) begin
      if (bus.dmemREN || bus.dmemWEN) begin
        acc_go  = 1'b1;
        acc_typ = bus.dmemWEN ? ACC_DW : ACC_DR;
        acc_idx = bus.dmemaddr[AW+1:2];
        acc_err = bad_addr(bus.dmemaddr) || (bus.dmemREN && bus.dmemWEN);
      end else if (bus.imemREN && !bus.halt) begin
        acc_go  = 1'b1;
        acc_typ = ACC_I;
        acc_idx = bus.imemaddr[AW+1:2];
        acc_err = bad_addr(bus.imemaddr);
      end
    end
  end

  // With zero latency the access completes straight from the bus values.
  assign f_typ   = (state_q == S_IDLE) ? acc_typ       : typ_q;
  assign f_idx   = (state_q == S_IDLE) ? acc_idx       : idx_q;
  assign f_store = (state_q == S_IDLE) ? bus.dmemstore : store_q;
  assign f_err   = (state_q == S_IDLE) ? acc_err       : err_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    typ_d     = typ_q;
    idx_d     = idx_q;
    store_d   = store_q;
    err_d     = err_q;
    ihit_d    = 1'b0;
    dhit_d    = 1'b0;
    aerr_d    = 1'b0;
    fire      = 1'b0;
    ram_we    = 1'b0;
    ram_idx   = bus.prog_addr[AW+1:2];
    ram_wdata = bus.prog_data;
    ld_i      = 1'b0;
    ld_d      = 1'b0;
    ld_err    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.prog_wen) begin
          ram_we = prog_in_range;
        end else if (acc_go) begin
          typ_d   = acc_typ;
          idx_d   = acc_idx;
          store_d = bus.dmemstore;
          err_d   = acc_err;
          cnt_d   = 4'(LAT);
          if (LAT == 0) begin
            state_d = S_HIT;
            fire    = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_HIT;
          fire    = 1'b1;
        end
      end
      S_HIT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (fire) begin
      ihit_d    = (f_typ == ACC_I);
      dhit_d    = (f_typ != ACC_I);
      aerr_d    = f_err;
      ram_idx   = f_idx;
      ram_wdata = f_store;
      ram_we    = (f_typ == ACC_DW) && !f_err;
      ld_i      = (f_typ == ACC_I);
      // A good write leaves dmemload alone; a faulted one reports ERR_WORD.
      ld_d      = (f_typ == ACC_DR) || ((f_typ == ACC_DW) && f_err);
      ld_err    = f_err;
    end
  end

  // RAM array: contents survive reset, but a write on a reset edge is lost.
  always_ff @(posedge CLK) begin
    if (ram_we && !RST) begin
      mem[ram_idx] <= ram_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      imemload_q <= '0;
      dmemload_q <= '0;
    end else begin
      if (ld_i) imemload_q <= ld_err ? ERR_WORD : mem[ram_idx];
      if (ld_d) dmemload_q <= ld_err ? ERR_WORD : mem[ram_idx];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      typ_q   <= ACC_I;
      idx_q   <= '0;
      store_q <= '0;
      err_q   <= 1'b0;
      ihit_q  <= 1'b0;
      dhit_q  <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      typ_q   <= typ_d;
      idx_q   <= idx_d;
      store_q <= store_d;
      err_q   <= err_d;
      ihit_q  <= ihit_d;
      dhit_q  <= dhit_d;
      aerr_q  <= aerr_d;
    end
  end

  assign bus.imemload = imemload_q;
  assign bus.dmemload = dmemload_q;
  assign bus.ihit     = ihit_q;
  assign bus.dhit     = dhit_q;
  assign bus.addr_err = aerr_q;
  assign bus.busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_dp_mem_responder.sv
// Bench for dp_mem_responder: LAT=2 and LAT=0 instances, directed sequences,
// a LAT=0 vector table and a randomized run against an array-based memory model.
module tb_dp_mem_responder;
  localparam int          DEPTH = 256;
  localparam logic [31:0] ERRW  = 32'hBAD1BAD1;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  dp_mem_if if2 ();
  dp_mem_if if0 ();

  dp_mem_responder #(.DEPTH(DEPTH), .LAT(2), .ERR_WORD(ERRW)) u_dut2 (
    .CLK(CLK), .RST(RST), .bus(if2.slave)
  );
  dp_mem_responder #(.DEPTH(DEPTH), .LAT(0), .ERR_WORD(ERRW)) u_dut0 (
    .CLK(CLK), .RST(RST), .bus(if0.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ref2 [DEPTH];
  logic [31:0] ref0 [DEPTH];
  logic [31:0] exp_i2, exp_d2;

  typedef struct {
    int          kind;   // 0=I 1=DR 2=DW 3=DR+DW
    logic [31:0] a;
    logic [31:0] st;
    logic [31:0] eload;
    logic        eerr;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  function automatic logic is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH));
  endfunction

  task automatic prog2(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    if2.prog_wen = 1'b1; if2.prog_addr = a; if2.prog_data = d;
    @(negedge CLK);
    if2.prog_wen = 1'b0;
    ref2[a[9:2]] = d;
  endtask

  task automatic prog0(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    if0.prog_wen = 1'b1; if0.prog_addr = a; if0.prog_data = d;
    @(negedge CLK);
    if0.prog_wen = 1'b0;
    ref0[a[9:2]] = d;
  endtask

  // One access on the LAT=2 instance; request is held through the HIT edge.
  task automatic access2(input int kind, input logic [31:0] a, input logic [31:0] st);
    logic       err;
    logic [7:0] idx;
    err = is_bad(a) || (kind == 3);
    idx = a[9:2];
    @(negedge CLK);
    if (kind == 0) begin
      if2.imemREN = 1'b1; if2.imemaddr = a;
    end else begin
      if2.dmemREN = (kind == 1) || (kind == 3);
      if2.dmemWEN = (kind >= 2);
      if2.dmemaddr = a; if2.dmemstore = st;
    end
    if (kind == 0)      exp_i2 = err ? ERRW : ref2[idx];
    else if (kind == 1) exp_d2 = err ? ERRW : ref2[idx];
    else if (err)       exp_d2 = ERRW;
    else                ref2[idx] = st;
    for (int k = 1; k <= 3; k++) begin
      @(posedge CLK); #1;
      if (k < 3) begin
        chk1("wait_ihit", if2.ihit, 1'b0);
        chk1("wait_dhit", if2.dhit, 1'b0);
        chk1("wait_busy", if2.busy, 1'b1);
      end else begin
        chk1("ihit", if2.ihit, kind == 0);
        chk1("dhit", if2.dhit, kind != 0);
        chk1("addr_err", if2.addr_err, err);
        chk("imemload", if2.imemload, exp_i2);
        chk("dmemload", if2.dmemload, exp_d2);
      end
    end
    @(posedge CLK); #1;
    chk1("post_busy", if2.busy, 1'b0);
    chk1("post_hits", if2.ihit | if2.dhit, 1'b0);
    @(negedge CLK);
    if2.dmemREN = 1'b0; if2.dmemWEN = 1'b0;
    if (kind == 0) if2.imemREN = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    if2.imemREN = 0; if2.imemaddr = 0; if2.dmemREN = 0; if2.dmemWEN = 0;
    if2.dmemaddr = 0; if2.dmemstore = 0; if2.halt = 0; if2.prog_wen = 0;
    if2.prog_addr = 0; if2.prog_data = 0;
    if0.imemREN = 0; if0.imemaddr = 0; if0.dmemREN = 0; if0.dmemWEN = 0;
    if0.dmemaddr = 0; if0.dmemstore = 0; if0.halt = 0; if0.prog_wen = 0;
    if0.prog_addr = 0; if0.prog_data = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk1("rst_ihit", if2.ihit, 1'b0);
    chk1("rst_dhit", if2.dhit, 1'b0);
    chk1("rst_busy", if2.busy, 1'b0);
    chk1("rst_aerr", if2.addr_err, 1'b0);
    chk("rst_iload", if2.imemload, 32'h0);
    chk("rst_dload", if2.dmemload, 32'h0);
    chk("rst0_dload", if0.dmemload, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    exp_i2 = 0; exp_d2 = 0;

    for (int i = 0; i < DEPTH; i++) prog2(32'(i * 4), $urandom);
    prog2(32'h10, 32'h2402000A);
    prog2(32'h44, 32'h12345678);

    // Continuous fetch: hits in cycles 3 and 7 only.
    @(negedge CLK);
    if2.imemREN = 1'b1; if2.imemaddr = 32'h10;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge CLK); #1;
      chk1("t1_ihit", if2.ihit, (cyc == 3) || (cyc == 7));
      chk1("t1_dhit", if2.dhit, 1'b0);
      if (cyc == 3) chk("t1_iload", if2.imemload, 32'h2402000A);
    end
    @(negedge CLK);
    if2.imemREN = 1'b0;
    exp_i2 = 32'h2402000A;

    access2(2, 32'h40, 32'hDEADBEEF);
    access2(1, 32'h40, 32'h0);

    // Simultaneous requests: data first, fetch address taken at second accept.
    @(negedge CLK);
    if2.imemREN = 1'b1; if2.imemaddr = 32'h10;
    if2.dmemREN = 1'b1; if2.dmemaddr = 32'h40;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(posedge CLK); #1;
      chk1("t3_dhit", if2.dhit, cyc == 3);
      chk1("t3_ihit", if2.ihit, cyc == 7);
      if (cyc == 3) begin
        chk("t3_dload", if2.dmemload, 32'hDEADBEEF);
        @(negedge CLK);
        if2.dmemREN = 1'b0; if2.imemaddr = 32'h44;
      end
      if (cyc == 7) chk("t3_iload", if2.imemload, 32'h12345678);
    end
    @(negedge CLK);
    if2.imemREN = 1'b0;
    exp_i2 = 32'h12345678;

    // Halted core: fetches blocked, data still served.
    @(negedge CLK);
    if2.halt = 1'b1; if2.imemREN = 1'b1; if2.imemaddr = 32'h10;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge CLK); #1;
      chk1("halt_ihit", if2.ihit, 1'b0);
      chk1("halt_busy", if2.busy, 1'b0);
    end
    access2(1, 32'h40, 32'h0);
    @(negedge CLK);
    if2.imemREN = 1'b0; if2.halt = 1'b0;

    // halt rising mid-access does not cancel the fetch.
    @(negedge CLK);
    if2.imemREN = 1'b1; if2.imemaddr = 32'h10;
    @(negedge CLK);
    if2.halt = 1'b1; if2.imemREN = 1'b0;
    @(posedge CLK); #1;
    chk1("haltw_ihit2", if2.ihit, 1'b0);
    @(posedge CLK); #1;
    chk1("haltw_ihit3", if2.ihit, 1'b1);
    chk("haltw_iload", if2.imemload, 32'h2402000A);
    exp_i2 = 32'h2402000A;
    @(negedge CLK);
    if2.halt = 1'b0;

    // LAT=0 vector table.
    prog0(32'h0, 32'hCAFEF00D);
    prog0(32'h8, 32'h22222222);
    tbl[0] = '{1, 32'h42,  32'h0,  ERRW,          1'b1};
    tbl[1] = '{2, 32'h400, 32'h55, ERRW,          1'b1};
    tbl[2] = '{1, 32'h0,   32'h0,  32'hCAFEF00D,  1'b0};
    tbl[3] = '{2, 32'h4,   32'h77, 32'hCAFEF00D,  1'b0};
    tbl[4] = '{1, 32'h4,   32'h0,  32'h77,        1'b0};
    tbl[5] = '{0, 32'h4,   32'h0,  32'h77,        1'b0};
    tbl[6] = '{3, 32'h8,   32'h99, ERRW,          1'b1};
    tbl[7] = '{1, 32'h8,   32'h0,  32'h22222222,  1'b0};
    tbl[8] = '{0, 32'h1,   32'h0,  ERRW,          1'b1};
    for (int v = 0; v < 9; v++) begin
      @(negedge CLK);
      if (tbl[v].kind == 0) begin
        if0.imemREN = 1'b1; if0.imemaddr = tbl[v].a;
      end else begin
        if0.dmemREN = (tbl[v].kind == 1) || (tbl[v].kind == 3);
        if0.dmemWEN = (tbl[v].kind >= 2);
        if0.dmemaddr = tbl[v].a; if0.dmemstore = tbl[v].st;
      end
      @(posedge CLK); #1;
      chk1("v_ihit", if0.ihit, tbl[v].kind == 0);
      chk1("v_dhit", if0.dhit, tbl[v].kind != 0);
      chk1("v_aerr", if0.addr_err, tbl[v].eerr);
      chk("v_load", (tbl[v].kind == 0) ? if0.imemload : if0.dmemload, tbl[v].eload);
      @(negedge CLK);
      if0.imemREN = 1'b0; if0.dmemREN = 1'b0; if0.dmemWEN = 1'b0;
      @(posedge CLK);
    end

    // Loader write blocks acceptance on the same edge.
    @(negedge CLK);
    if0.prog_wen = 1'b1; if0.prog_addr = 32'h0C; if0.prog_data = 32'hABCD;
    if0.dmemREN = 1'b1; if0.dmemaddr = 32'h0C;
    @(posedge CLK); #1;
    chk1("prog_blk_dhit", if0.dhit, 1'b0);
    @(negedge CLK);
    if0.prog_wen = 1'b0;
    @(posedge CLK); #1;
    chk1("prog_rd_dhit", if0.dhit, 1'b1);
    chk("prog_rd_dload", if0.dmemload, 32'hABCD);
    @(negedge CLK);
    if0.dmemREN = 1'b0;
    @(posedge CLK);

    // Reset during WAIT of a write.
    prog2(32'h08, 32'h11111111);
    @(negedge CLK);
    if2.dmemWEN = 1'b1; if2.dmemaddr = 32'h08; if2.dmemstore = 32'h99999999;
    @(posedge CLK); #1;
    chk1("rw_busy", if2.busy, 1'b1);
    @(negedge CLK);
    RST = 1'b1; if2.dmemWEN = 1'b0;
    @(posedge CLK); #1;
    chk1("rw_dhit", if2.dhit, 1'b0);
    chk1("rw_ihit", if2.ihit, 1'b0);
    chk1("rw_aerr", if2.addr_err, 1'b0);
    chk1("rw_busy0", if2.busy, 1'b0);
    chk("rw_iload", if2.imemload, 32'h0);
    chk("rw_dload", if2.dmemload, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    exp_i2 = 0; exp_d2 = 0;
    access2(1, 32'h08, 32'h0);

    // Randomized accesses against the array model.
    for (int n = 0; n < 80; n++) begin
      int          r, sel, kind;
      logic [31:0] a;
      r   = $urandom_range(0, 9);
      sel = $urandom_range(0, 7);
      if (sel == 0)      a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 1) a = 32'($urandom_range(256, 1 << 20)) << 2;
      else               a = 32'($urandom_range(0, 255)) << 2;
      if (r == 0) begin
        prog2(32'($urandom_range(0, 255)) << 2, $urandom);
      end else begin
        kind = (r == 9) ? 3 : ((r - 1) % 3);
        access2(kind, a, $urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
